btn_conditioner: RTL

//  Upstream input stage for the badge push-buttons. Takes the raw active-low
//  btn pins and produces clean, clock-synchronous signals for the LED/display logic:
//  - debounced levels
//  - single-cycle press/release strobes
//  - an auto-repeat strobe for held buttons
//  It feeds the LED/shooting pattern logic, which must never see a raw pin.

---
 rtl/badge_pkg.sv | 17 +
 rtl/btn_conditioner_if.sv | 28 ++
 rtl/btn_conditioner_ch.sv | 103 ++++++++++
 rtl/btn_conditioner.sv | 41 ++++
 4 files changed

// File: rtl/badge_pkg.sv
// Shared badge definitions: clock rate, millisecond-to-cycle helper and the
// auto-repeat state encoding used by the button conditioner.
package badge_pkg;

    localparam int unsigned CLK_HZ = 32_000_000;

    function automatic int unsigned ms_to_cyc(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    typedef enum logic [1:0] {
        RptIdle   = 2'd0,
        RptDelay  = 2'd1,
        RptPeriod = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw active-low pins in, conditioned levels and strobes out.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = 5
) ();

    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    modport master (
        output btn_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  btn_n,
        output pressed,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );

endinterface

// File: rtl/btn_conditioner_ch.sv
// One button channel: 2-FF synchronizer, counter debounce and auto-repeat FSM.
// All outputs are registered; pulses last exactly one cycle.
module btn_conditioner_ch
    import badge_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = ms_to_cyc(10),
    parameter int unsigned RPT_DELAY  = ms_to_cyc(500),
    parameter int unsigned RPT_PERIOD = ms_to_cyc(100)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic             sync_ff1_q;
    logic             sync_ff2_q;
    logic             sync;
    logic             stable_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    rpt_state_e       state_q;
    logic             mismatch;
    logic             db_done;

    assign sync     = ~sync_ff2_q;
    assign mismatch = (sync != stable_q);
    assign db_done  = mismatch && (db_cnt_q == DB_W'(DB_CYCLES - 1));
    assign pressed  = stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1_q    <= 1'b1;
            sync_ff2_q    <= 1'b1;
            stable_q      <= 1'b0;
            db_cnt_q      <= '0;
            rpt_cnt_q     <= '0;
            state_q       <= RptIdle;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_ff1_q    <= btn_n;
            sync_ff2_q    <= sync_ff1_q;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            if (!mismatch) begin
                db_cnt_q <= '0;
            end else if (db_done) begin
                stable_q <= sync;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end

            // An accepted edge overrides any repeat expiry landing in the same cycle.
            if (db_done && sync) begin
                press_pulse  <= 1'b1;
                repeat_pulse <= 1'b1;
                rpt_cnt_q    <= '0;
                state_q      <= RptDelay;
            end else if (db_done) begin
                release_pulse <= 1'b1;
                rpt_cnt_q     <= '0;
                state_q       <= RptIdle;
            end else begin
                case (state_q)
                    RptDelay: begin
                        if (rpt_cnt_q == RPT_W'(RPT_DELAY - 1)) begin
                            repeat_pulse <= 1'b1;
                            rpt_cnt_q    <= '0;
                            state_q      <= RptPeriod;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    RptPeriod: begin
                        if (rpt_cnt_q == RPT_W'(RPT_PERIOD - 1)) begin
                            repeat_pulse <= 1'b1;
                            rpt_cnt_q    <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        rpt_cnt_q <= '0;
                        state_q   <= RptIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Badge push-button input stage: one independent conditioning channel per pin.
module btn_conditioner
    import badge_pkg::*;
#(
    parameter int unsigned N_BTN      = 5,
    parameter int unsigned DB_CYCLES  = ms_to_cyc(10),
    parameter int unsigned RPT_DELAY  = ms_to_cyc(500),
    parameter int unsigned RPT_PERIOD = ms_to_cyc(100)
) (
    input  logic                clk,
    input  logic                rst_n,
    btn_conditioner_if.slave    bus
);

    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_conditioner_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_n         (bus.btn_n[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign bus.pressed       = pressed;
    assign bus.press_pulse   = press_pulse;
    assign bus.release_pulse = release_pulse;
    assign bus.repeat_pulse  = repeat_pulse;

endmodule
